// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor.
// One GROUP-bit look-ahead group is resolved per stage. Each stage passes on
// the sum bits resolved so far, the operand bits not yet processed, and the
// group carry. A single advance enable moves or holds the whole pipeline, and
// the last stage registers the result and flags.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG = WIDTH / GROUP;

  // Reject geometries that cannot be split into equal look-ahead groups.
  if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > 8 || NG < 1) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, with 2 <= GROUP <= 8");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // Subtraction is a + ~b + ~borrow_in, so only the B operand and the
  // incoming carry need to be conditioned.
  assign w_b_eff = sub ? ~b : b;
  assign w_c_eff = sub ? ~cin : cin;

  // The pipeline moves whenever the output slot is empty or is being consumed.
  // This depends only on the output handshake, never on in_valid.
  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  // One look-ahead group. Each carry is a flat sum of generate/propagate
  // products, so no carry waits on its neighbour. Returns {carry_out, sum}.
  function automatic logic [GROUP:0] cla_group(
    input logic [GROUP-1:0] i_x,
    input logic [GROUP-1:0] i_y,
    input logic             i_c
  );
    logic [GROUP-1:0] l_p;
    logic [GROUP-1:0] l_g;
    logic [GROUP:0]   l_c;
    logic [GROUP-1:0] l_s;
    logic             l_term;
    l_p    = i_x ^ i_y;
    l_g    = i_x & i_y;
    l_c    = '0;
    l_c[0] = i_c;
    for (int j = 0; j < int'(GROUP); j++) begin
      l_c[j+1] = 1'b0;
      // Generate at bit k, propagated through bits k+1..j.
      for (int k = 0; k <= j; k++) begin
        l_term = l_g[k];
        for (int m = k + 1; m <= j; m++) begin
          l_term = l_term & l_p[m];
        end
        l_c[j+1] = l_c[j+1] | l_term;
      end
      // Group carry-in, propagated through bits 0..j.
      l_term = i_c;
      for (int m = 0; m <= j; m++) begin
        l_term = l_term & l_p[m];
      end
      l_c[j+1] = l_c[j+1] | l_term;
    end
    l_s = l_p ^ l_c[GROUP-1:0];
    return {l_c[GROUP], l_s};
  endfunction

  for (genvar gi = 0; gi < NG; gi++) begin : gen_stg
    localparam int unsigned LO = int'(gi) * GROUP;
    localparam int unsigned HI = LO + GROUP - 1;

    // w_x: bits below LO hold sum bits already resolved; bits from LO up are
    // still A. w_y holds the B operand bits (already conditioned for
    // subtraction) that have not been processed yet.
    logic [WIDTH-1:0]  w_x;
    logic [WIDTH-1:LO] w_y;
    logic              w_ci;
    logic              w_vi;
    logic [GROUP:0]    w_res;
    logic [WIDTH-1:0]  w_xn;

    if (gi == 0) begin : g_head
      assign w_x  = a;
      assign w_y  = w_b_eff;
      assign w_ci = w_c_eff;
      assign w_vi = in_valid;
    end else begin : g_body
      assign w_x  = gen_stg[gi-1].g_mid.r_x;
      assign w_y  = gen_stg[gi-1].g_mid.r_y;
      assign w_ci = gen_stg[gi-1].g_mid.r_c;
      assign w_vi = gen_stg[gi-1].g_mid.r_v;
    end

    assign w_res = cla_group(w_x[HI:LO], w_y[HI:LO], w_ci);

    // Splice this group's sum bits into the word passed downstream.
    always_comb begin
      w_xn        = w_x;
      w_xn[HI:LO] = w_res[GROUP-1:0];
    end

    if (gi < NG - 1) begin : g_mid
      logic [WIDTH-1:0]    r_x;
      logic [WIDTH-1:HI+1] r_y;
      logic                r_c;
      logic                r_v;

      // Intermediate stage: holds the partial sum, the remaining operands, the carry, and a valid bit.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_x <= '0;
          r_y <= '0;
          r_c <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_vi;
          r_x <= w_xn;
          r_y <= w_y[WIDTH-1:HI+1];
          r_c <= w_res[GROUP];
        end
      end
    end else begin : g_last
      // Final stage: registers the result and its flags. The sign bits used
      // for overflow are the copies carried down the pipeline.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
          r_sum       <= '0;
          r_cout      <= 1'b0;
          r_ovf       <= 1'b0;
          r_zero      <= 1'b0;
        end else if (w_adv) begin
          r_out_valid <= w_vi;
          r_sum       <= w_xn;
          r_cout      <= w_res[GROUP];
          r_ovf       <= (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_xn[WIDTH-1] != w_x[WIDTH-1]);
          r_zero      <= (w_xn == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// The reference model computes each result arithmetically when the set is
// accepted and passes it through an NG-slot delay line that advances with
// the handshake.
module tb_pipelined_cla_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned G  = 4;
  localparam int unsigned NG = W / G;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_ret = 0;

  logic m_v [NG];
  res_t m_r [NG];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  function automatic res_t ref_model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                     input logic ic, input logic isub);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   t;
    res_t         r;
    be     = isub ? ~ib : ib;
    ce     = isub ? ~ic : ic;
    t      = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, ce};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (ia[W-1] == be[W-1]) && (r.sum[W-1] != ia[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < int'(NG); i++) begin
      if (m_v[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, take the edge, update the model.
  task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic isub, input logic ordy, output logic acc);
    logic exp_adv;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = isub;
    out_ready = ordy;
    #1;
    exp_adv = !m_v[NG-1] || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_adv));
    chk("out_valid", 32'(out_valid), 32'(m_v[NG-1]));
    if (m_v[NG-1]) begin
      chk("sum",  32'(sum),  32'(m_r[NG-1].sum));
      chk("cout", 32'(cout), 32'(m_r[NG-1].cout));
      chk("ovf",  32'(ovf),  32'(m_r[NG-1].ovf));
      chk("zero", 32'(zero), 32'(m_r[NG-1].zero));
    end
    acc = rst_n && iv && exp_adv;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < int'(NG); i++) m_v[i] = 1'b0;
    end else if (exp_adv) begin
      if (m_v[NG-1]) n_ret++;
      for (int i = int'(NG) - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_r[i] = m_r[i-1];
      end
      m_v[0] = iv;
      m_r[0] = ref_model(ia, ib, ic, isub);
    end
    @(negedge clk);
  endtask

  // Single set with out_ready held high; checks fixed expected values at the latency point.
  task automatic run_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic isub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input logic ez);
    logic acc;
    tick(1'b1, ia, ib, ic, isub, 1'b1, acc);
    chk("dir_accept", 32'(acc), 32'd1);
    repeat (NG - 1) tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    #1;
    chk("dir_valid", 32'(out_valid), 32'd1);
    chk("dir_sum",   32'(sum),       32'(es));
    chk("dir_cout",  32'(cout),      32'(ec));
    chk("dir_ovf",   32'(ovf),       32'(eo));
    chk("dir_zero",  32'(zero),      32'(ez));
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Backstop so a broken design cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc;
    logic [W+2:0] snap;
    logic [W-1:0] opa [8];
    logic [W-1:0] opb [8];
    logic         opc [8];
    logic         ops [8];
    int unsigned  idx;
    int unsigned  ret0;

    for (int i = 0; i < int'(NG); i++) begin
      m_v[i] = 1'b0;
      m_r[i] = '0;
    end

    // Reset with in_valid high; the offered set must be ignored.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 16'hABCD;
    b         = 16'h1234;
    cin       = 1'b1;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    rst_n = 1'b1;
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);

    // Directed arithmetic corner cases.
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Eight back-to-back sets with out_ready low for three cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
      opc[i] = 1'($urandom);
      ops[i] = 1'($urandom);
    end
    idx  = 0;
    ret0 = n_ret;
    snap = '0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || model_busy()); cyc++) begin
      if (cyc == 6) begin
        snap = {sum, cout, ovf, zero};
        chk("stall_valid", 32'(out_valid), 32'd1);
      end
      if (cyc >= 7 && cyc <= 9) chk("stall_hold", 32'({sum, cout, ovf, zero}), 32'(snap));
      if (idx < 8)
        tick(1'b1, opa[idx], opb[idx], opc[idx], ops[idx], !(cyc >= 6 && cyc < 9), acc);
      else
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 32'd8);
    chk("bp_retired", n_ret - ret0, 32'd8);

    // Reset with three sets in flight.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
    end
    rst_n = 1'b0;
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, acc);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum",   32'(sum),       32'd0);
    chk("mid_rst_cout",  32'(cout),      32'd0);
    chk("mid_rst_ovf",   32'(ovf),       32'd0);
    chk("mid_rst_zero",  32'(zero),      32'd0);
    repeat (6) tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    // Random operands with random valid and ready patterns.
    repeat (10000) begin
      tick($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    repeat (NG + 2) tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("final_drained", 32'(model_busy()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
